// File: rtl/fixed_point_pkg.sv
// Shared widths, clamp limits and FSM encoding for the fixed-point accumulator.
package fixed_point_pkg;

    // Total word width of a Qm.n number (sign bit is part of the integer part).
    function automatic int unsigned number_width(input int unsigned int_bits,
                                                 input int unsigned frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Largest representable two's-complement value of the given width.
    function automatic longint max_pos(input int unsigned width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Most negative representable two's-complement value of the given width.
    function automatic longint min_neg(input int unsigned width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/fixed_point_add_sub_sat.sv
// Combinational saturating signed add/subtract: result = sat(a +/- b).
module fixed_point_add_sub_sat
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] result,
    output logic                    saturated
);

    localparam logic signed [WIDTH-1:0] MaxPos = WIDTH'(max_pos(WIDTH));
    localparam logic signed [WIDTH-1:0] MinNeg = WIDTH'(min_neg(WIDTH));

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] b_term;
    logic signed [WIDTH:0] sum;

    // One guard bit is enough: negating MIN_NEG and the extreme sums all fit in WIDTH+1 bits.
    always_comb begin
        a_ext     = {a[WIDTH-1], a};
        b_ext     = {b[WIDTH-1], b};
        b_term    = sub ? -b_ext : b_ext;
        sum       = a_ext + b_term;
        saturated = (sum[WIDTH] != sum[WIDTH-1]);
        if (saturated) begin
            result = sum[WIDTH] ? MinNeg : MaxPos;
        end else begin
            result = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Framed saturating Qm.n accumulator with valid/ready on input and a held frame result.
module fixed_point_accumulator
    import fixed_point_pkg::*;
#(
    parameter int unsigned INTEGER_PART_WIDTH    = 8,
    parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
    parameter int unsigned COUNT_WIDTH           = 8
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] in_data,
    input  logic                                                in_sub,
    input  logic                                                in_first,
    input  logic                                                in_last,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]                              out_count,
    output logic                                                out_saturated
);

    localparam int unsigned NUMBER_WIDTH =
        number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    state_e                  state_q, state_d;
    logic [NUMBER_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    sat_q, sat_d;
    logic [NUMBER_WIDTH-1:0] out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0]  out_count_q, out_count_d;
    logic                    out_sat_q, out_sat_d;

    logic                    beat;
    logic [NUMBER_WIDTH-1:0] base;
    logic [NUMBER_WIDTH-1:0] beat_sum;
    logic                    beat_sat;
    logic [COUNT_WIDTH-1:0]  count_base;
    logic [COUNT_WIDTH-1:0]  count_inc;
    logic                    sat_inc;

    // A first beat starts from zero so any partial frame is dropped.
    always_comb begin
        beat       = in_valid && in_ready;
        base       = in_first ? '0 : acc_q;
        count_base = in_first ? '0 : count_q;
        count_inc  = (count_base == CountMax) ? count_base : count_base + 1'b1;
        sat_inc    = (in_first ? 1'b0 : sat_q) | beat_sat;
    end

    fixed_point_add_sub_sat #(
        .WIDTH(NUMBER_WIDTH)
    ) u_add_sub_sat (
        .a        (base),
        .b        (in_data),
        .sub      (in_sub),
        .result   (beat_sum),
        .saturated(beat_sat)
    );

    // State register, async clear to the idle accumulate state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Next-state: accumulate accepted beats, latch the result on the last one, clear on handoff.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        unique case (state_q)
            ACCUM: begin
                if (beat) begin
                    acc_d   = beat_sum;
                    count_d = count_inc;
                    sat_d   = sat_inc;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_data_d  = beat_sum;
                        out_count_d = count_inc;
                        out_sat_d   = sat_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Outputs: handshake flags decode from state, data comes straight from the result registers.
    always_comb begin
        in_ready      = (state_q == ACCUM);
        out_valid     = (state_q == HOLD);
        out_data      = out_data_q;
        out_count     = out_count_q;
        out_saturated = out_sat_q;
    end

endmodule
